perf_sampler: RTL and testbench

Autonomous sampling initiator for the hardware performance counter CSR block. On a programmable interval it sweeps the enabled `mhpmcounter` indices over the counter block's SRAM-like read/write port and streams each 64-bit value with its index on a valid/ready interface toward trace/debug. It sits beside the CSR file and shares the counter port through an external arbiter, which grants `req_o`.

---
 rtl/perf_sampler.sv | 164 ++++++++++++++++
 tb/tb_perf_sampler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_sampler.sv
// Periodic sweeper of the enabled mhpmcounters, streaming {idx, value} samples to trace/debug.
// Define PERF_SAMPLER_CLEAR_EN to zero each counter after it is read (delta sampling).
module perf_sampler #(
  parameter int XLEN        = 64,
  parameter int NumCounters = 29,
  parameter int IntervalW   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [IntervalW-1:0]   interval_i,
  input  logic [NumCounters-1:0] counter_mask_i,
  output logic                   req_o,
  input  logic                   grant_i,
  output logic [11:0]            addr_o,
  output logic                   we_o,
  output logic [XLEN-1:0]        data_o,
  input  logic [XLEN-1:0]        data_i,
  output logic                   sample_valid_o,
  input  logic                   sample_ready_i,
  output logic [4:0]             sample_idx_o,
  output logic [63:0]            sample_data_o,
  output logic                   sample_last_o,
  output logic [7:0]             sample_seq_o,
  output logic                   busy_o,
  output logic                   overrun_o
);

  typedef enum logic [2:0] {IDLE, SCAN, RD_LO, RD_HI, CLR_LO, CLR_HI, PUSH} state_t;

  state_t                 state, state_nxt;
  logic [IntervalW-1:0]   timer;
  logic                   enable_q;
  logic                   tick;
  logic [NumCounters-1:0] mask_q;
  logic [4:0]             idx;
  logic [4:0]             bit_sel;
  logic [63:0]            value;
  logic [7:0]             seq;
  logic                   overrun;
  logic                   sweep_start, idx_inc, cap_lo, cap_hi, last;
  logic [11:0]            addr_lo, addr_hi;
  state_t                 after_reads;

  // The cycle enable rises only loads the timer, so the first tick lands interval+1 cycles later.
  assign tick        = enable_i && enable_q && (timer == '0);
  assign sweep_start = tick && (state == IDLE) && (|counter_mask_i);
  assign bit_sel     = idx - 5'd1;
  assign last        = (mask_q >> idx) == '0;
  assign addr_lo     = 12'hB02 + {7'd0, idx};
  assign addr_hi     = 12'hB82 + {7'd0, idx};

`ifdef PERF_SAMPLER_CLEAR_EN
  assign after_reads = CLR_LO;
`else
  assign after_reads = PUSH;
  assign we_o        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable_q <= 1'b0;
      timer    <= '0;
    end else begin
      enable_q <= enable_i;
      if (!enable_i)                     timer <= '0;
      else if (!enable_q || timer == '0) timer <= interval_i;
      else                               timer <= timer - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      mask_q  <= '0;
      idx     <= '0;
      seq     <= '0;
      value   <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (sweep_start) begin
        mask_q <= counter_mask_i;
        idx    <= 5'd1;
        seq    <= seq + 8'd1;
      end else if (idx_inc) begin
        idx <= idx + 5'd1;
      end
      if (cap_lo) value <= 64'(data_i);
      if (cap_hi) value[63:32] <= data_i[31:0];
      if (tick && state != IDLE) overrun <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    req_o     = 1'b0;
    addr_o    = '0;
    idx_inc   = 1'b0;
    cap_lo    = 1'b0;
    cap_hi    = 1'b0;
`ifdef PERF_SAMPLER_CLEAR_EN
    we_o      = 1'b0;
`endif
    case (state)
      IDLE: if (sweep_start) state_nxt = SCAN;
      SCAN: begin
        if (mask_q[bit_sel])             state_nxt = RD_LO;
        else if (idx == 5'(NumCounters)) state_nxt = IDLE;
        else                             idx_inc   = 1'b1;
      end
      RD_LO: begin
        req_o  = 1'b1;
        addr_o = addr_lo;
        if (grant_i) begin
          cap_lo    = 1'b1;
          state_nxt = (XLEN == 32) ? RD_HI : after_reads;
        end
      end
      RD_HI: begin
        req_o  = 1'b1;
        addr_o = addr_hi;
        if (grant_i) begin
          cap_hi    = 1'b1;
          state_nxt = after_reads;
        end
      end
`ifdef PERF_SAMPLER_CLEAR_EN
      CLR_LO: begin
        req_o  = 1'b1;
        we_o   = 1'b1;
        addr_o = addr_lo;
        if (grant_i) state_nxt = (XLEN == 32) ? CLR_HI : PUSH;
      end
      CLR_HI: begin
        req_o  = 1'b1;
        we_o   = 1'b1;
        addr_o = addr_hi;
        if (grant_i) state_nxt = PUSH;
      end
`endif
      PUSH: begin
        if (sample_ready_i) begin
          if (last) state_nxt = IDLE;
          else begin
            idx_inc   = 1'b1;
            state_nxt = SCAN;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign data_o         = '0;
  assign busy_o         = (state != IDLE);
  assign sample_valid_o = (state == PUSH);
  assign sample_last_o  = (state == PUSH) && last;
  assign sample_idx_o   = idx;
  assign sample_data_o  = value;
  assign sample_seq_o   = seq;
  assign overrun_o      = overrun;

endmodule

// File: tb/tb_perf_sampler.sv
// Directed bench: a 64-bit instance for sweep/timing/backpressure/reset, a 32-bit one for split reads.
module tb_perf_sampler;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        en_a, grant_a, ready_a, req_a, we_a, valid_a, last_a, busy_a, ovr_a;
  logic [31:0] int_a;
  logic [28:0] mask_a;
  logic [11:0] addr_a;
  logic [63:0] dout_a, din_a, sdata_a;
  logic [4:0]  idx_a;
  logic [7:0]  seq_a;

  logic        en_b, grant_b, ready_b, req_b, we_b, valid_b, last_b, busy_b, ovr_b;
  logic [31:0] int_b, dout_b, din_b;
  logic [28:0] mask_b;
  logic [11:0] addr_b;
  logic [63:0] sdata_b;
  logic [4:0]  idx_b;
  logic [7:0]  seq_b;

  logic [63:0] cnt [0:31];
  logic [11:0] addr_q[$];
  int cyc = 0, req_cnt_a = 0, n_cmp = 0, n_err = 0;
  logic any_we = 1'b0, any_dout = 1'b0;

  perf_sampler #(.XLEN(64), .NumCounters(29), .IntervalW(32)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en_a), .interval_i(int_a), .counter_mask_i(mask_a),
    .req_o(req_a), .grant_i(grant_a), .addr_o(addr_a), .we_o(we_a), .data_o(dout_a), .data_i(din_a),
    .sample_valid_o(valid_a), .sample_ready_i(ready_a), .sample_idx_o(idx_a), .sample_data_o(sdata_a),
    .sample_last_o(last_a), .sample_seq_o(seq_a), .busy_o(busy_a), .overrun_o(ovr_a));

  perf_sampler #(.XLEN(32), .NumCounters(29), .IntervalW(32)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en_b), .interval_i(int_b), .counter_mask_i(mask_b),
    .req_o(req_b), .grant_i(grant_b), .addr_o(addr_b), .we_o(we_b), .data_o(dout_b), .data_i(din_b),
    .sample_valid_o(valid_b), .sample_ready_i(ready_b), .sample_idx_o(idx_b), .sample_data_o(sdata_b),
    .sample_last_o(last_b), .sample_seq_o(seq_b), .busy_o(busy_b), .overrun_o(ovr_b));

  // Counter block model: 0xB02+k is the low half of counter k, 0xB82+k the high half.
  always_comb begin
    din_a = '0;
    if (req_a) din_a = cnt[5'(addr_a - 12'hB02)];
  end

  always_comb begin
    logic [63:0] w;
    w     = '0;
    din_b = '0;
    if (req_b) begin
      if (addr_b >= 12'hB83) begin
        w     = cnt[5'(addr_b - 12'hB82)];
        din_b = w[63:32];
      end else begin
        w     = cnt[5'(addr_b - 12'hB02)];
        din_b = w[31:0];
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_a) req_cnt_a <= req_cnt_a + 1;
    if (we_a === 1'b1 || we_b === 1'b1) any_we <= 1'b1;
    if (dout_a != 64'd0 || dout_b != 32'd0) any_dout <= 1'b1;
    if (req_b && grant_b) addr_q.push_back(addr_b);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return valid_a;
      1: return busy_a;
      2: return req_a;
      default: return valid_b;
    endcase
  endfunction

  task automatic wait_for(input int which, input int maxc, input string tag, output int t);
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk);
      if (sig(which)) begin
        t = cyc;
        return;
      end
    end
    check(tag, 64'(sig(which)), 64'd1);
    t = -1;
  endtask

  int t_en, t1, t2, t;
  int r0;

  initial begin
    for (int i = 0; i < 32; i++) cnt[i] = 64'd0;
    rst_n = 1'b0;
    {en_a, grant_a, ready_a, en_b, grant_b, ready_b} = '0;
    int_a = '0; int_b = '0; mask_a = '0; mask_b = '0;
    repeat (3) @(negedge clk);
    check("rst_req", 64'(req_a), 64'd0);
    check("rst_addr", 64'(addr_a), 64'd0);
    check("rst_valid", 64'(valid_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_seq", 64'(seq_a), 64'd0);
    check("rst_ovr", 64'(ovr_a), 64'd0);
    rst_n = 1'b1;

    // Basic sweep, mask 0b101, interval 99
    cnt[1] = 64'h10; cnt[3] = 64'h30;
    mask_a = 29'b101; int_a = 99; grant_a = 1'b1; ready_a = 1'b1;
    @(negedge clk);
    en_a = 1'b1; t_en = cyc;
    wait_for(1, 200, "tick1_timeout", t1);
    check("first_tick_delay", 64'(t1 - t_en), 64'd101);
    check("seq1", 64'(seq_a), 64'd1);
    wait_for(2, 10, "req1_timeout", t);
    check("rd_addr_c1", 64'(addr_a), 64'hB03);
    check("rd_we_c1", 64'(we_a), 64'd0);
    wait_for(0, 10, "s1_timeout", t);
    check("s1_idx", 64'(idx_a), 64'd1);
    check("s1_data", sdata_a, 64'h10);
    check("s1_last", 64'(last_a), 64'd0);
    wait_for(0, 10, "s2_timeout", t);
    check("s2_idx", 64'(idx_a), 64'd3);
    check("s2_data", sdata_a, 64'h30);
    check("s2_last", 64'(last_a), 64'd1);
    @(negedge clk);
    check("sweep1_done", 64'(busy_a), 64'd0);

    // Second sweep 100 cycles later; enable falls mid-sweep
    cnt[1] = 64'h15;
    wait_for(1, 200, "tick2_timeout", t2);
    check("tick_period", 64'(t2 - t1), 64'd100);
    check("seq2", 64'(seq_a), 64'd2);
    wait_for(0, 10, "s3_timeout", t);
    check("s3_data", sdata_a, 64'h15);
    en_a = 1'b0;
    wait_for(0, 10, "s4_timeout", t);
    check("s4_idx_after_disable", 64'(idx_a), 64'd3);
    repeat (120) @(negedge clk);
    check("no_tick_disabled_seq", 64'(seq_a), 64'd2);
    check("no_tick_disabled_busy", 64'(busy_a), 64'd0);
    check("no_overrun_yet", 64'(ovr_a), 64'd0);

    // Backpressure with a short interval
    mask_a = 29'b1; int_a = 3; ready_a = 1'b0; cnt[1] = 64'h77;
    @(negedge clk);
    en_a = 1'b1;
    wait_for(0, 20, "bp_timeout", t);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_held", 64'(valid_a), 64'd1);
      check("bp_data_stable", sdata_a, 64'h77);
    end
    check("bp_overrun", 64'(ovr_a), 64'd1);
    check("bp_seq", 64'(seq_a), 64'd3);
    ready_a = 1'b1; en_a = 1'b0;
    @(negedge clk);
    check("bp_done", 64'(busy_a), 64'd0);
    repeat (20) @(negedge clk);
    check("bp_no_extra_sweep", 64'(seq_a), 64'd3);

    // Grant stall
    grant_a = 1'b0; mask_a = 29'b10; cnt[2] = 64'h22; int_a = 9;
    @(negedge clk);
    en_a = 1'b1;
    wait_for(2, 30, "gs_req_timeout", t);
    check("gs_addr", 64'(addr_a), 64'hB04);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gs_req_held", 64'(req_a), 64'd1);
      check("gs_addr_held", 64'(addr_a), 64'hB04);
    end
    grant_a = 1'b1;
    @(negedge clk);
    check("gs_valid", 64'(valid_a), 64'd1);
    check("gs_data", sdata_a, 64'h22);
    check("gs_idx", 64'(idx_a), 64'd2);
    check("gs_last", 64'(last_a), 64'd1);
    check("gs_seq", 64'(seq_a), 64'd4);
    en_a = 1'b0;
    @(negedge clk);

    // Reset while a sample is held
    ready_a = 1'b0; mask_a = 29'b1; int_a = 3;
    @(negedge clk);
    en_a = 1'b1;
    wait_for(0, 20, "rp_timeout", t);
    rst_n = 1'b0; en_a = 1'b0;
    #1;
    check("rp_valid", 64'(valid_a), 64'd0);
    check("rp_busy", 64'(busy_a), 64'd0);
    check("rp_data", sdata_a, 64'd0);
    check("rp_idx", 64'(idx_a), 64'd0);
    check("rp_seq", 64'(seq_a), 64'd0);
    check("rp_ovr", 64'(ovr_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; ready_a = 1'b1;
    repeat (3) @(negedge clk);
    check("rp_idle_after", 64'(busy_a), 64'd0);

    // Empty mask over five ticks
    mask_a = '0; int_a = 3;
    r0 = req_cnt_a;
    en_a = 1'b1;
    repeat (22) @(negedge clk);
    check("empty_no_req", 64'(req_cnt_a - r0), 64'd0);
    check("empty_seq", 64'(seq_a), 64'd0);
    check("empty_busy", 64'(busy_a), 64'd0);
    en_a = 1'b0;

    // Split 32-bit reads
    cnt[2] = 64'h1_0000_0005;
    mask_b = 29'b10; int_b = 4; grant_b = 1'b1; ready_b = 1'b1;
    @(negedge clk);
    en_b = 1'b1;
    wait_for(3, 30, "sr_timeout", t);
    check("sr_data", sdata_b, 64'h0000_0001_0000_0005);
    check("sr_idx", 64'(idx_b), 64'd2);
    check("sr_last", 64'(last_b), 64'd1);
    check("sr_nreads", 64'(addr_q.size()), 64'd2);
    if (addr_q.size() >= 2) begin
      check("sr_addr_lo", 64'(addr_q[0]), 64'hB04);
      check("sr_addr_hi", 64'(addr_q[1]), 64'hB84);
    end
    en_b = 1'b0;
    repeat (5) @(negedge clk);

`ifndef PERF_SAMPLER_CLEAR_EN
    check("we_never_set", 64'(any_we), 64'd0);
`endif
    check("data_o_zero", 64'(any_dout), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
